sr_sdram_burst_writer: RTL and testbench

Drain side of the super-resolution output pixel FIFO. It reads 17-bit pixel words from the FIFO read port in fixed-length bursts and stages each burst locally. It then issues a request/ack/data-strobe burst write to the SDRAM controller, advancing a frame-relative address. It resynchronises to frames using the start-of-frame flag carried in bit 16 of each word.

---
 rtl/sr_pkg.sv | 14 +
 rtl/sr_burst_buf.sv | 23 ++
 rtl/sr_sdram_burst_writer.sv | 129 ++++++++++++
 tb/tb_sr_sdram_burst_writer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and widths for the super-resolution output path.
// Pixel words carry RGB565 in the low 16 bits and a start-of-frame flag above them.
package sr_pkg;
    localparam int SR_PIX_W   = 17;
    localparam int SR_SOF_BIT = 16;
    localparam int SR_RGB_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        REQ  = 2'd2,
        XFER = 2'd3
    } sr_wr_state_t;
endpackage

// File: rtl/sr_burst_buf.sv
// Burst staging buffer: one write port fed from the FIFO capture path,
// asynchronous read port indexed by the transfer counter.
module sr_burst_buf
    import sr_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int IDX_W     = $clog2(BURST_LEN)
) (
    input  logic                clk_w,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_widx,
    input  logic [SR_RGB_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]    i_ridx,
    output logic [SR_RGB_W-1:0] o_rdata
);
    logic [BURST_LEN-1:0][SR_RGB_W-1:0] r_mem;

    always_ff @(posedge clk_w) begin
        if (i_we) r_mem[i_widx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/sr_sdram_burst_writer.sv
// Drains the pixel FIFO in fixed bursts, stages each burst, then writes it to
// SDRAM at base_addr + offset, resynchronising to frames on the SOF flag.
module sr_sdram_burst_writer
    import sr_pkg::*;
#(
    parameter int DATA_WIDTH   = 17,
    parameter int COUNT_WIDTH  = 10,
    parameter int BURST_LEN    = 8,
    parameter int ADDR_WIDTH   = 24,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                   clk_w,
    input  logic                   rst_n,
    input  logic [COUNT_WIDTH-1:0] fifo_count,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    output logic                   fifo_rd,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   sdram_wr_req,
    input  logic                   sdram_wr_ack,
    input  logic                   sdram_wr_data_req,
    output logic [ADDR_WIDTH-1:0]  sdram_addr,
    output logic [6:0]             sdram_wr_len,
    output logic [15:0]            sdram_data_out,
    output logic                   frame_done,
    output logic                   sync_err
);
    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam int PIX_W = $clog2(FRAME_PIXELS + 1);

    localparam logic [COUNT_WIDTH-1:0] LP_BL_CNT   = COUNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_W-1:0]       LP_BL_FILL  = CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0]       LP_LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [PIX_W-1:0]       LP_BL_PIX   = PIX_W'(BURST_LEN);
    localparam logic [PIX_W-1:0]       LP_FRAME    = PIX_W'(FRAME_PIXELS);
    localparam logic [ADDR_WIDTH-1:0]  LP_BL_ADDR  = ADDR_WIDTH'(BURST_LEN);

    sr_wr_state_t           r_state, w_next;
    logic [CNT_W-1:0]       r_fill_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [ADDR_WIDTH-1:0]  r_offset;
    logic [PIX_W-1:0]       r_pixel_cnt;
    logic                   r_frame_done, r_sync_err;

    logic                   w_cap, w_sof, w_resync, w_sof_err, w_last_strobe;
    logic [IDX_W-1:0]       w_cap_idx;
    logic [PIX_W-1:0]       w_pix_sum;
    logic [SR_RGB_W-1:0]    w_rdata;

    // fill counter k>0 means word k-1 is on fifo_dout this cycle
    assign w_cap         = (r_state == FILL) && (r_fill_cnt != '0);
    assign w_cap_idx     = IDX_W'(r_fill_cnt - CNT_W'(1));
    assign w_sof         = fifo_dout[SR_SOF_BIT];
    assign w_resync      = w_cap && w_sof && (w_cap_idx == '0) && (r_pixel_cnt != '0);
    assign w_sof_err     = w_cap && w_sof && ((w_cap_idx != '0) || (r_pixel_cnt != '0));
    assign w_last_strobe = (r_state == XFER) && sdram_wr_data_req && (r_idx == LP_LAST_IDX);
    assign w_pix_sum     = r_pixel_cnt + LP_BL_PIX;

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        fifo_rd      = 1'b0;
        sdram_wr_req = 1'b0;
        case (r_state)
            IDLE: if (fifo_count >= LP_BL_CNT) w_next = FILL;
            FILL: begin
                fifo_rd = (r_fill_cnt != LP_BL_FILL);
                if (r_fill_cnt == LP_BL_FILL) w_next = REQ;
            end
            REQ: begin
                sdram_wr_req = 1'b1;
                if (sdram_wr_ack) w_next = XFER;
            end
            XFER: if (w_last_strobe) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt   <= '0;
            r_idx        <= '0;
            r_offset     <= '0;
            r_pixel_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_sync_err   <= w_sof_err;
            if ((r_state == FILL) && (r_fill_cnt != LP_BL_FILL)) r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            else                                                 r_fill_cnt <= '0;
            // power-of-two burst: idx wraps to 0 on the last strobe
            if (r_state != XFER)        r_idx <= '0;
            else if (sdram_wr_data_req) r_idx <= r_idx + IDX_W'(1);
            if (w_resync) begin
                r_pixel_cnt <= '0;
                r_offset    <= '0;
            end else if (w_last_strobe) begin
                if (w_pix_sum == LP_FRAME) begin
                    r_pixel_cnt  <= '0;
                    r_offset     <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_pixel_cnt  <= w_pix_sum;
                    r_offset     <= r_offset + LP_BL_ADDR;
                end
            end
        end
    end

    sr_burst_buf #(.BURST_LEN(BURST_LEN), .IDX_W(IDX_W)) u_buf (
        .clk_w   (clk_w),
        .i_we    (w_cap),
        .i_widx  (w_cap_idx),
        .i_wdata (fifo_dout[SR_RGB_W-1:0]),
        .i_ridx  (r_idx),
        .o_rdata (w_rdata)
    );

    assign sdram_addr     = base_addr + r_offset;
    assign sdram_wr_len   = 7'(BURST_LEN);
    assign sdram_data_out = (r_state == XFER) ? w_rdata : '0;
    assign frame_done     = r_frame_done;
    assign sync_err       = r_sync_err;
endmodule

// File: tb/tb_sr_sdram_burst_writer.sv
// Bench for sr_sdram_burst_writer: queue-backed FIFO, scripted SDRAM controller,
// and a frame-position model that predicts addresses, data and pulse counts.
module tb_sr_sdram_burst_writer;
    localparam int BL    = 8;
    localparam int FRAME = 16;

    logic        clk_w = 1'b0;
    logic        rst_n;
    logic [9:0]  fifo_count;
    logic [16:0] fifo_dout;
    logic        fifo_rd;
    logic [23:0] base_addr;
    logic        sdram_wr_req, sdram_wr_ack, sdram_wr_data_req;
    logic [23:0] sdram_addr;
    logic [6:0]  sdram_wr_len;
    logic [15:0] sdram_data_out;
    logic        frame_done, sync_err;

    sr_sdram_burst_writer #(
        .DATA_WIDTH(17), .COUNT_WIDTH(10), .BURST_LEN(BL),
        .ADDR_WIDTH(24), .FRAME_PIXELS(FRAME)
    ) dut (
        .clk_w(clk_w), .rst_n(rst_n), .fifo_count(fifo_count), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .base_addr(base_addr), .sdram_wr_req(sdram_wr_req),
        .sdram_wr_ack(sdram_wr_ack), .sdram_wr_data_req(sdram_wr_data_req),
        .sdram_addr(sdram_addr), .sdram_wr_len(sdram_wr_len), .sdram_data_out(sdram_data_out),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk_w = ~clk_w;

    logic [16:0] fifo_q [$];
    logic [16:0] cur_w [BL];
    int n_chk = 0, n_err = 0;
    int fd_seen = 0, se_seen = 0;
    int m_pix = 0, m_fd = 0, m_se = 0;

    // FIFO read port: data appears one cycle after the strobe
    always begin
        logic rd_l;
        @(negedge clk_w);
        rd_l = fifo_rd;
        @(posedge clk_w);
        #1;
        if (rd_l && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_count = 10'(fifo_q.size());
    end

    always @(negedge clk_w) begin
        if (frame_done) fd_seen++;
        if (sync_err)   se_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fifo_rd"}, 32'(fifo_rd), 0);
        chk({tag, "_wr_req"}, 32'(sdram_wr_req), 0);
        chk({tag, "_data_out"}, 32'(sdram_data_out), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_sync_err"}, 32'(sync_err), 0);
        chk({tag, "_addr"}, 32'(sdram_addr), 32'(base_addr));
    endtask

    task automatic run_burst(input int ack_dly, input bit gap, input int abort_at,
                             input logic [23:0] exp_addr, output bit aborted);
        int n, w;
        aborted = 1'b0;
        w = 0;
        do begin @(negedge clk_w); w++; end while (!fifo_rd && w < 40);
        chk("rd_latency", w, 1);
        if (!fifo_rd) return;
        n = 0;
        while (fifo_rd && n < 40) begin n++; @(negedge clk_w); end
        chk("rd_pulses", n, BL);
        chk("req_low_at_last_capture", 32'(sdram_wr_req), 0);
        @(negedge clk_w);
        chk("req_rise", 32'(sdram_wr_req), 1);
        if (!sdram_wr_req) return;
        chk("addr", 32'(sdram_addr), 32'(exp_addr));
        chk("wr_len", 32'(sdram_wr_len), BL);
        for (int d = 0; d < ack_dly; d++) begin
            @(negedge clk_w);
            chk("req_hold", 32'(sdram_wr_req), 1);
            chk("addr_req", 32'(sdram_addr), 32'(exp_addr));
        end
        // strobe in the ack cycle must not advance the burst
        sdram_wr_ack = 1'b1;
        sdram_wr_data_req = 1'b1;
        @(negedge clk_w);
        sdram_wr_ack = 1'b0;
        n = 0;
        w = 0;
        while (n < BL && w < 100) begin
            if (n == abort_at) begin aborted = 1'b1; break; end
            chk("data", 32'(sdram_data_out), 32'(cur_w[n][15:0]));
            chk("addr_xfer", 32'(sdram_addr), 32'(exp_addr));
            sdram_wr_data_req = gap ? (w % 3 == 0) : 1'b1;
            if (sdram_wr_data_req) n++;
            w++;
            @(negedge clk_w);
        end
        sdram_wr_data_req = 1'b0;
        if (!aborted) begin
            chk("strobes", n, BL);
            chk("req_after_burst", 32'(sdram_wr_req), 0);
        end
    endtask

    task automatic send(input int sof_pos, input int ack_dly, input bit gap, input int abort_at);
        logic [23:0] ea;
        bit ab;
        for (int k = 0; k < BL; k++) cur_w[k] = {k == sof_pos, 16'($urandom)};
        if (cur_w[0][16] && m_pix != 0) begin m_pix = 0; m_se++; end
        for (int k = 1; k < BL; k++) if (cur_w[k][16]) m_se++;
        ea = base_addr + 24'(m_pix);
        for (int k = 0; k < BL; k++) fifo_q.push_back(cur_w[k]);
        fifo_count = 10'(fifo_q.size());
        run_burst(ack_dly, gap, abort_at, ea, ab);
        if (ab) begin
            rst_n = 1'b0;
            #1;
            chk_reset("rst_mid");
            m_pix = 0;
            @(negedge clk_w);
            chk_reset("rst_hold");
            rst_n = 1'b1;
        end else begin
            m_pix += BL;
            if (m_pix == FRAME) begin m_pix = 0; m_fd++; end
            @(negedge clk_w);
            @(negedge clk_w);
            chk("frame_done_count", fd_seen, m_fd);
            chk("sync_err_count", se_seen, m_se);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fifo_count = '0;
        fifo_dout = '0;
        sdram_wr_ack = 1'b0;
        sdram_wr_data_req = 1'b0;
        base_addr = 24'($urandom);
        repeat (3) @(negedge clk_w);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk_w);
        chk_reset("idle");

        // contiguous strobes, ack two cycles after request
        send(-1, 2, 1'b0, -1);
        send(-1, 2, 1'b0, -1);
        // gapped strobes, including an ack in the request's first cycle
        send(-1, 1, 1'b1, -1);
        send(-1, 0, 1'b1, -1);

        // two clean frames with address wrap past 2^24
        base_addr = 24'hFFFFFC;
        send(0, 2, 1'b0, -1);
        send(-1, 3, 1'b0, -1);
        send(0, 1, 1'b0, -1);
        send(-1, 2, 1'b0, -1);

        // early SOF at pixel 8 resyncs to base
        send(-1, 1, 1'b0, -1);
        send(0, 1, 1'b0, -1);
        send(-1, 1, 1'b0, -1);

        // SOF inside a burst: flagged, no resync
        send(-1, 1, 1'b0, -1);
        send(3, 2, 1'b1, -1);

        base_addr = 24'($urandom);
        for (int i = 0; i < 8; i++) begin
            int sp;
            sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
            send(sp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
        end

        // reset after three strobes, then a fresh burst restarts at base
        send(-1, 1, 1'b0, 3);
        send(-1, 1, 1'b0, -1);
        send(-1, 0, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
